// File: rtl/clause_cell_n_if.sv
// Bus bundle for one clause cell. The bin array or bench drives the master
// side and the cell sits on the slave side.
interface clause_cell_n_if #(
   parameter int NUM_LITS = 8,
   parameter int CNT_W    = 4
);
   logic                    wr_i;
   logic [2*NUM_LITS-1:0]   lit_code_i;
   logic                    eval_i;
   logic [3*NUM_LITS-1:0]   var_value_frombase_i;
   logic [3*NUM_LITS-1:0]   var_value_tobase_o;
   logic                    imp_drv_i;
   logic                    imp_valid_o;
   logic                    busy_o;
   logic                    done_o;
   logic [CNT_W-1:0]        freelitcnt_o;
   logic                    clausesat_o;
   logic                    unit_o;
   logic                    conflict_o;
   logic [NUM_LITS-1:0]     cclause_o;
   logic                    cclause_drv_i;

   modport master (
      output wr_i, lit_code_i, eval_i, var_value_frombase_i, imp_drv_i, cclause_drv_i,
      input  var_value_tobase_o, imp_valid_o, busy_o, done_o, freelitcnt_o,
             clausesat_o, unit_o, conflict_o, cclause_o
   );

   modport slave (
      input  wr_i, lit_code_i, eval_i, var_value_frombase_i, imp_drv_i, cclause_drv_i,
      output var_value_tobase_o, imp_valid_o, busy_o, done_o, freelitcnt_o,
             clausesat_o, unit_o, conflict_o, cclause_o
   );
endinterface

// File: rtl/clause_cell_n.sv
// Clause evaluator holding one clause of up to NUM_LITS literals. It samples
// the variable values, classifies the clause as sat / unit / conflict, and can
// drive a one-cycle implication for the single remaining free literal.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting; accepts clause writes (priority) or an eval start
// SAMPLE  | registering the variable values from the base
// DECIDE  | registering status flags, count and unit slot; done pulse
// IMPLY   | driving the unit literal back to the base for one cycle
module clause_cell_n #(
   parameter int NUM_LITS = 8,
   parameter int CNT_W    = 4
) (
   input  logic            clk,
   input  logic            rst,
   clause_cell_n_if.slave  bus
);

   localparam int IDX_W = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SAMPLE = 2'd1,
      S_DECIDE = 2'd2,
      S_IMPLY  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [2*NUM_LITS-1:0] lit_q, lit_d;
   logic [3*NUM_LITS-1:0] var_q, var_d;
   logic                  sat_q, sat_d;
   logic                  unit_q, unit_d;
   logic                  conf_q, conf_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;

   logic [NUM_LITS-1:0]   present;
   logic [NUM_LITS-1:0]   lit_true;
   logic [NUM_LITS-1:0]   lit_free;
   logic [CNT_W-1:0]      cnt_c;
   logic [IDX_W-1:0]      idx_c;
   logic                  sat_c;
   logic                  unit_c;
   logic                  conf_c;

   // Per-slot literal classification against the sampled values; the implied
   // bit of each lane plays no part in the truth value.
   always_comb begin
      present  = '0;
      lit_true = '0;
      lit_free = '0;
      for (int i = 0; i < NUM_LITS; i++) begin
         present[i]  = (lit_q[2*i +: 2] == 2'b01) || (lit_q[2*i +: 2] == 2'b10);
         lit_true[i] = ((lit_q[2*i +: 2] == 2'b01) && (var_q[3*i +: 2] == 2'b01)) ||
                       ((lit_q[2*i +: 2] == 2'b10) && (var_q[3*i +: 2] == 2'b10));
         lit_free[i] = present[i] &&
                       (var_q[3*i +: 2] != 2'b01) && (var_q[3*i +: 2] != 2'b10);
      end
   end

   // Free-literal count and lowest-indexed free slot (scanned high to low so
   // the lowest index is the last one written).
   always_comb begin
      cnt_c = '0;
      idx_c = '0;
      for (int i = 0; i < NUM_LITS; i++) begin
         cnt_c = cnt_c + CNT_W'(lit_free[i]);
      end
      for (int i = NUM_LITS - 1; i >= 0; i--) begin
         if (lit_free[i]) begin
            idx_c = IDX_W'(i);
         end
      end
   end

   // Clause status derived from the classification; exclusive by construction.
   always_comb begin
      sat_c  = |lit_true;
      unit_c = !sat_c && (cnt_c == CNT_W'(1));
      conf_c = !sat_c && (cnt_c == '0);
   end

   // State and data register; reset also aborts any evaluation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         lit_q   <= '0;
         var_q   <= '0;
         sat_q   <= 1'b0;
         unit_q  <= 1'b0;
         conf_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         lit_q   <= lit_d;
         var_q   <= var_d;
         sat_q   <= sat_d;
         unit_q  <= unit_d;
         conf_q  <= conf_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and register-update logic; requests outside IDLE are dropped.
   always_comb begin
      state_d = state_q;
      lit_d   = lit_q;
      var_d   = var_q;
      sat_d   = sat_q;
      unit_d  = unit_q;
      conf_d  = conf_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.wr_i) begin
               lit_d  = bus.lit_code_i;
               sat_d  = 1'b0;
               unit_d = 1'b0;
               conf_d = 1'b0;
               cnt_d  = '0;
            end else if (bus.eval_i) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            var_d   = bus.var_value_frombase_i;
            state_d = S_DECIDE;
         end
         S_DECIDE: begin
            sat_d  = sat_c;
            unit_d = unit_c;
            conf_d = conf_c;
            cnt_d  = cnt_c;
            idx_d  = idx_c;
            if (unit_c && bus.imp_drv_i) begin
               state_d = S_IMPLY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_IMPLY: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Decoded outputs: the implied lane carries {1, polarity code}, which is
   // 101 for a positive and 110 for a negative literal.
   always_comb begin
      bus.busy_o             = (state_q != S_IDLE);
      bus.done_o             = (state_q == S_DECIDE);
      bus.imp_valid_o        = (state_q == S_IMPLY);
      bus.var_value_tobase_o = '0;
      if (state_q == S_IMPLY) begin
         for (int i = 0; i < NUM_LITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
               bus.var_value_tobase_o[3*i +: 3] = {1'b1, lit_q[2*i +: 2]};
            end
         end
      end
   end

   // Registered status flags and the conflict-clause mask for learning.
   always_comb begin
      bus.clausesat_o  = sat_q;
      bus.unit_o       = unit_q;
      bus.conflict_o   = conf_q;
      bus.freelitcnt_o = cnt_q;
      bus.cclause_o    = (conf_q && bus.cclause_drv_i) ? present : '0;
   end

endmodule

// File: tb/tb_clause_cell_n.sv
// Directed bench for clause_cell_n with NUM_LITS=4: a table of clause/value
// vectors plus hand sequences for write/eval collision, eval during SAMPLE,
// and reset during DECIDE.
module tb_clause_cell_n;
   localparam int N  = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   clause_cell_n_if #(.NUM_LITS(N), .CNT_W(CW)) bus ();

   clause_cell_n #(.NUM_LITS(N), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic [7:0]  code;
      logic [11:0] vals;
      logic        imp_drv;
      logic        sat;
      logic        unit;
      logic        conf;
      logic [2:0]  cnt;
      logic        imply;
      logic [11:0] tobase;
      logic [3:0]  ccl;
   } vec_t;

   vec_t vecs[7];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " busy"}, 32'(bus.busy_o), 32'd0);
      check({tag, " done"}, 32'(bus.done_o), 32'd0);
      check({tag, " imp_valid"}, 32'(bus.imp_valid_o), 32'd0);
      check({tag, " tobase"}, 32'(bus.var_value_tobase_o), 32'd0);
      check({tag, " flags"}, 32'({bus.clausesat_o, bus.unit_o, bus.conflict_o}), 32'd0);
      check({tag, " cnt"}, 32'(bus.freelitcnt_o), 32'd0);
   endtask

   task automatic apply_vec(input vec_t v);
      @(posedge clk); #1;
      bus.wr_i = 1'b1; bus.lit_code_i = v.code; bus.eval_i = 1'b0; bus.cclause_drv_i = 1'b0;
      @(posedge clk); #1;
      bus.wr_i = 1'b0; bus.var_value_frombase_i = v.vals; bus.imp_drv_i = v.imp_drv;
      bus.eval_i = 1'b1;
      @(negedge clk);
      check({v.name, " cleared flags"},
            32'({bus.clausesat_o, bus.unit_o, bus.conflict_o, bus.freelitcnt_o}), 32'd0);
      check({v.name, " idle busy"}, 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;
      bus.eval_i = 1'b0;
      @(negedge clk);
      check({v.name, " sample busy"}, 32'(bus.busy_o), 32'd1);
      check({v.name, " sample done"}, 32'(bus.done_o), 32'd0);
      @(negedge clk);
      check({v.name, " decide done"}, 32'(bus.done_o), 32'd1);
      check({v.name, " decide flags hidden"},
            32'({bus.clausesat_o, bus.unit_o, bus.conflict_o}), 32'd0);
      @(negedge clk);
      check({v.name, " sat"}, 32'(bus.clausesat_o), 32'(v.sat));
      check({v.name, " unit"}, 32'(bus.unit_o), 32'(v.unit));
      check({v.name, " conflict"}, 32'(bus.conflict_o), 32'(v.conf));
      check({v.name, " cnt"}, 32'(bus.freelitcnt_o), 32'(v.cnt));
      check({v.name, " done gone"}, 32'(bus.done_o), 32'd0);
      check({v.name, " imp_valid"}, 32'(bus.imp_valid_o), 32'(v.imply));
      check({v.name, " busy after decide"}, 32'(bus.busy_o), 32'(v.imply));
      check({v.name, " tobase"}, 32'(bus.var_value_tobase_o), 32'(v.tobase));
      bus.cclause_drv_i = 1'b1; #1;
      check({v.name, " cclause drv1"}, 32'(bus.cclause_o), 32'(v.ccl));
      bus.cclause_drv_i = 1'b0; #1;
      check({v.name, " cclause drv0"}, 32'(bus.cclause_o), 32'd0);
      @(negedge clk);
      check({v.name, " end busy"}, 32'(bus.busy_o), 32'd0);
      check({v.name, " end imp_valid"}, 32'(bus.imp_valid_o), 32'd0);
      check({v.name, " end tobase"}, 32'(bus.var_value_tobase_o), 32'd0);
      check({v.name, " flags held"},
            32'({bus.clausesat_o, bus.unit_o, bus.conflict_o, bus.freelitcnt_o}),
            32'({v.sat, v.unit, v.conf, v.cnt}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic seen_done;
      logic seen_imp;

      //          name        code   vals    imp sat unit conf cnt imply tobase  ccl
      vecs[0] = '{"unit_pos",  8'h19, 12'h00A, 1, 0, 1, 0, 3'd1, 1, 12'h140, 4'b0000};
      vecs[1] = '{"sat",       8'h19, 12'h04A, 1, 1, 0, 0, 3'd0, 0, 12'h000, 4'b0000};
      vecs[2] = '{"conflict",  8'h19, 12'h08A, 1, 0, 0, 1, 3'd0, 0, 12'h000, 4'b0111};
      vecs[3] = '{"empty",     8'h00, 12'h00A, 1, 0, 0, 1, 3'd0, 0, 12'h000, 4'b0000};
      vecs[4] = '{"unit_nodrv",8'h19, 12'h00A, 0, 0, 1, 0, 3'd0 + 3'd1, 0, 12'h000, 4'b0000};
      vecs[5] = '{"all_free",  8'h55, 12'h000, 1, 0, 0, 0, 3'd4, 0, 12'h000, 4'b0000};
      vecs[6] = '{"unit_neg",  8'hA0, 12'h140, 1, 0, 1, 0, 3'd1, 1, 12'hC00, 4'b0000};

      rst = 1'b0;
      bus.wr_i = 1'b0; bus.lit_code_i = '0; bus.eval_i = 1'b0;
      bus.var_value_frombase_i = '0; bus.imp_drv_i = 1'b0; bus.cclause_drv_i = 1'b1;
      #12;
      check_zero_outputs("reset");
      check("reset cclause", 32'(bus.cclause_o), 32'd0);
      bus.cclause_drv_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 7; k++) begin
         apply_vec(vecs[k]);
      end

      // write and eval together: write wins, eval dropped
      apply_vec(vecs[3]);
      @(posedge clk); #1;
      bus.wr_i = 1'b1; bus.eval_i = 1'b1; bus.lit_code_i = 8'h19;
      @(posedge clk); #1;
      bus.wr_i = 1'b0; bus.eval_i = 1'b0;
      @(negedge clk);
      check("collide flags cleared",
            32'({bus.clausesat_o, bus.unit_o, bus.conflict_o, bus.freelitcnt_o}), 32'd0);
      seen_done = 1'b0;
      seen_imp  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         seen_done = seen_done | bus.done_o | bus.busy_o;
         @(negedge clk);
      end
      check("collide no eval", 32'(seen_done), 32'd0);

      // eval pulsed during SAMPLE is ignored; unit without permission
      @(posedge clk); #1;
      bus.wr_i = 1'b1; bus.lit_code_i = 8'h19;
      @(posedge clk); #1;
      bus.wr_i = 1'b0; bus.var_value_frombase_i = 12'h00A; bus.imp_drv_i = 1'b0;
      bus.eval_i = 1'b1;
      @(posedge clk); #1;
      bus.eval_i = 1'b1;
      @(posedge clk); #1;
      bus.eval_i = 1'b0;
      @(negedge clk);
      check("sample-eval decide done", 32'(bus.done_o), 32'd1);
      seen_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seen_done = seen_done | bus.done_o | bus.busy_o;
         seen_imp  = seen_imp | bus.imp_valid_o;
      end
      check("sample-eval no requeue", 32'(seen_done), 32'd0);
      check("sample-eval no imply", 32'(seen_imp), 32'd0);
      check("sample-eval unit", 32'({bus.unit_o, bus.freelitcnt_o}), 32'({1'b1, 3'd1}));

      // reset during DECIDE
      @(posedge clk); #1;
      bus.imp_drv_i = 1'b1; bus.eval_i = 1'b1;
      @(posedge clk); #1;
      bus.eval_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst-mid decide done", 32'(bus.done_o), 32'd1);
      rst = 1'b0;
      #1;
      check_zero_outputs("rst-mid");
      @(negedge clk);
      check_zero_outputs("rst-mid held");
      rst = 1'b1;
      apply_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/clause_cell_n.md
Name: clause_cell_n

Overview:
Parametrised clause evaluator for the SAT bin array, the successor to the fixed two-literal cell pair. It stores one clause of up to NUM_LITS literals and evaluates it against variable values from the base on request. It reports sat, unit and conflict status plus the free-literal count. It issues a one-cycle implication for the unit literal and exposes a conflict-clause mask for learning.

Parameters:
NUM_LITS, 8, number of literal slots (>=2)
CNT_W, 4, width of free-literal count; must be >= clog2(NUM_LITS+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_i  in  1  load clause polarities (accepted only in IDLE)
lit_code_i  in  2*NUM_LITS  per-slot code: 01 positive, 10 negative, 00/11 absent
eval_i  in  1  start evaluation (accepted only in IDLE)
var_value_frombase_i  in  3*NUM_LITS  per-slot {implied, val[1:0]}; val 01 true, 10 false, 00/11 free
var_value_tobase_o  out  3*NUM_LITS  per-slot implication drive; 3'b000 = no drive
imp_drv_i  in  1  permit implication in DECIDE
imp_valid_o  out  1  one-cycle pulse while the implication is driven
busy_o  out  1  high in SAMPLE, DECIDE, IMPLY
done_o  out  1  one-cycle pulse in DECIDE
freelitcnt_o  out  CNT_W  registered count of present, free literals
clausesat_o  out  1  registered: some present literal is true
unit_o  out  1  registered: not sat and freelitcnt == 1
conflict_o  out  1  registered: not sat and freelitcnt == 0 (includes empty clause)
cclause_o  out  NUM_LITS  conflict-clause mask
cclause_drv_i  in  1  enable cclause_o

Behaviour:
- Slot i occupies bits [3i+2:3i] of the var buses and [2i+1:2i] of lit_code_i.
- On reset: state=IDLE, all stored lit codes 00, all status flags 0, freelitcnt_o 0, var_value_tobase_o 0, imp_valid_o/done_o/busy_o 0.
- Literal status:
  - Positive literal is true when val=01 and false when val=10.
  - Negative literal is the opposite.
  - Otherwise the literal is free.
  - Absent slots are ignored.
- FSM IDLE:
  - wr_i=1: latch lit_code_i and clear sat/unit/conflict/freelitcnt; stay in IDLE.
  - Else eval_i=1: go to SAMPLE.
  - wr_i and eval_i together: the write wins and eval is dropped.
- FSM SAMPLE (1 cycle): register var_value_frombase_i; go to DECIDE.
- FSM DECIDE (1 cycle):
  - Register status flags, freelitcnt and the unit slot index (lowest-indexed free present slot).
  - done_o=1.
  - If the next-state unit condition holds and imp_drv_i=1: go to IMPLY.
  - Else go to IDLE.
  - Flags are visible from the cycle after DECIDE.
- FSM IMPLY (1 cycle):
  - Drive the unit slot lane = {1'b1, 01} for a positive literal or {1'b1, 10} for a negative literal; all other lanes 000.
  - imp_valid_o=1; then go to IDLE.
- Latency: eval_i accepted at cycle 0 -> done_o at cycle 2 -> implication at cycle 3.
- wr_i/eval_i outside IDLE are ignored; no queuing.
- Status flags hold until the next wr_i or completed DECIDE.
- clausesat_o, unit_o and conflict_o are mutually exclusive.
- cclause_o is combinational from registered state: when conflict_o && cclause_drv_i, bit i=1 for each present slot; else all 0.
- Reset asserted mid-evaluation aborts immediately to the reset values.

Test Plan:
- NUM_LITS=4, codes slot0..3 = 01,10,01,00; values x0=10, x1=01, x2=00; eval_i, imp_drv_i=1 -> done_o at cycle 2; unit_o=1, freelitcnt_o=1; cycle 3 var_value_tobase_o slot2=3'b101, other lanes 0, imp_valid_o=1.
- Same clause, x2=01 -> clausesat_o=1, unit_o=0, freelitcnt_o=0, no IMPLY, busy_o low after cycle 2.
- Same clause, x2=10 -> conflict_o=1; cclause_drv_i=1 gives cclause_o=4'b0111, cclause_drv_i=0 gives 0.
- All codes 00, eval -> conflict_o=1, freelitcnt_o=0; then wr_i and eval_i in the same cycle -> flags cleared, no done_o.
- Unit case with imp_drv_i=0 -> unit_o=1, no IMPLY, imp_valid_o stays 0; eval_i pulsed during SAMPLE is ignored.
- rst low during DECIDE -> all outputs 0 and state IDLE; a new eval after release completes normally.
